// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_BUBBLE = 32'h0;

  typedef struct packed {
    logic            filled;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// rtl/fetch_slot_queue.sv - ring of fetch slots: allocate on request, fill on response, pop at decode
module fetch_slot_queue
  import riscv_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int UW = $clog2(QDEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            alloc_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [XLEN-1:0] fill_inst_i,
  input  logic            consume_i,
  output logic [UW-1:0]   used_o,
  output logic [UW-1:0]   unfilled_o,
  output fetch_slot_t     head_o
);

  fetch_slot_t   slots_q [QDEPTH];
  fetch_slot_t   slots_d [QDEPTH];
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q, fill_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [UW-1:0] used_q, used_d;
  logic [UW-1:0] unfilled_q, unfilled_d;
  logic          do_fill;
  logic          do_consume;

  assign head_o     = slots_q[rd_ptr_q];
  assign used_o     = used_q;
  assign unfilled_o = unfilled_q;
  // A fill with nothing allocated-but-unfilled has no slot to land in and is ignored.
  assign do_fill    = fill_i && (unfilled_q != '0);
  assign do_consume = consume_i && slots_q[rd_ptr_q].filled;

  // Next-state: clear wins; otherwise alloc, fill and consume always touch distinct slots
  always_comb begin
    slots_d     = slots_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    used_d      = used_q;
    unfilled_d  = unfilled_q;
    if (clear_i) begin
      for (int i = 0; i < QDEPTH; i++) begin
        slots_d[i].filled = 1'b0;
      end
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      rd_ptr_d    = '0;
      used_d      = '0;
      unfilled_d  = '0;
    end else begin
      if (alloc_i) begin
        slots_d[alloc_ptr_q].filled = 1'b0;
        slots_d[alloc_ptr_q].pc     = alloc_pc_i;
        slots_d[alloc_ptr_q].inst   = INST_BUBBLE;
        alloc_ptr_d                 = alloc_ptr_q + PW'(1);
      end
      if (do_fill) begin
        slots_d[fill_ptr_q].filled = 1'b1;
        slots_d[fill_ptr_q].inst   = fill_inst_i;
        fill_ptr_d                 = fill_ptr_q + PW'(1);
      end
      if (do_consume) begin
        slots_d[rd_ptr_q].filled = 1'b0;
        rd_ptr_d                 = rd_ptr_q + PW'(1);
      end
      used_d     = used_q + UW'(alloc_i) - UW'(do_consume);
      unfilled_d = unfilled_q + UW'(alloc_i) - UW'(do_fill);
    end
  end

  // Slot and pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < QDEPTH; i++) begin
        slots_q[i] <= '0;
      end
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      used_q      <= '0;
      unfilled_q  <= '0;
    end else begin
      slots_q     <= slots_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      used_q      <= used_d;
      unfilled_q  <= unfilled_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, in-order memory requests, redirect squash
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          QDEPTH   = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst
);

  localparam int UW = $clog2(QDEPTH + 1);
  localparam int DW = $clog2(MAX_OUT + 1);
  localparam int IW = $clog2(QDEPTH + MAX_OUT + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [UW-1:0]   used;
  logic [UW-1:0]   unfilled;
  logic [IW-1:0]   inflight;
  logic            req_fire;
  logic            resp_keep;
  logic            consume;
  fetch_slot_t     head;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Outstanding words: live requests awaiting their slot plus squashed ones still to arrive.
  assign inflight = IW'(unfilled) + IW'(drop_cnt_q);

  // Request only with a guaranteed landing slot; the reset term keeps the bus quiet while held.
  assign imem_req_valid = !rst && !redirect_valid
                        && (used < UW'(QDEPTH))
                        && (inflight < IW'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign consume        = id_valid && id_ready;

  assign id_valid = head.filled;
  assign id_pc    = head.filled ? head.pc : '0;
  assign id_inst  = head.filled ? head.inst : INST_BUBBLE;

  fetch_slot_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (redirect_valid),
    .alloc_i     (req_fire),
    .alloc_pc_i  (fetch_pc_q),
    .fill_i      (resp_keep),
    .fill_inst_i (imem_resp_data),
    .consume_i   (consume),
    .used_o      (used),
    .unfilled_o  (unfilled),
    .head_o      (head)
  );

  // Next fetch PC and squash count; a redirect overrides both and re-counts what is still owed
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      if (inflight > IW'(imem_resp_valid)) begin
        drop_cnt_d = DW'(inflight - IW'(imem_resp_valid));
      end else begin
        drop_cnt_d = '0;
      end
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - DW'(1);
      end
    end
  end

  // Fetch PC and squash-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // A word arriving with nothing outstanding means memory and fetch have lost sync.
  resp_has_owner: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with an in-order variable-latency memory
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        mem_ready;
  logic [31:0] imem_req_addr;
  logic        mem_rv;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  always #5 clk = ~clk;

  fetch_unit #(.QDEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (mem_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (mem_rv && !rst),
    .imem_resp_data  (mem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_pc           (id_pc),
    .id_inst         (id_inst)
  );

  typedef struct { logic [31:0] addr; int due; } mem_req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; int cyc; } id_rec_t;

  mem_req_t mem_q[$];
  id_rec_t  id_log[$];
  int       cyc = 0;
  int       resp_delay = 1;
  int       max_out_seen = 0;
  int       n_checks = 0;
  int       n_pass = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A13_0000;
  endfunction

  // Memory: accept on the edge, answer resp_delay edges later, strictly in order
  always @(posedge clk) begin
    if (rst) begin
      mem_q.delete();
      max_out_seen <= 0;
    end else if (imem_req_valid && mem_ready) begin
      mem_q.push_back('{imem_req_addr, cyc + resp_delay});
      if (mem_q.size() > max_out_seen) max_out_seen <= mem_q.size();
    end
    cyc <= cyc + 1;
  end

  // Memory response driver, set up half a cycle ahead of the edge that captures it
  always @(negedge clk) begin
    mem_rv    <= 1'b0;
    mem_rdata <= 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
      mem_rv    <= 1'b1;
      mem_rdata <= mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
  end

  // Decode-side log of every accepted instruction
  always @(posedge clk) begin
    if (rst) id_log.delete();
    else if (id_valid && id_ready) id_log.push_back('{id_pc, id_inst, cyc});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int t = 0;
    while (id_log.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check({tag, " log count"}, 32'(id_log.size() >= n), 32'd1);
  endtask

  task automatic do_reset(input int delay);
    rst            = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(2);
    resp_delay = delay;
    rst        = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    mem_ready      = 1'b1;
    id_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    tick(1);
    check("reset id_valid", 32'(id_valid), 32'd0);
    check("reset id_pc", id_pc, 32'h0);
    check("reset id_inst", id_inst, 32'h0);
    check("reset req_valid", 32'(imem_req_valid), 32'd0);
    check("reset req_addr", imem_req_addr, 32'h0);

    // Zero-wait stream: first instruction two cycles after release, then one per cycle
    do_reset(1);
    id_ready = 1'b1;
    tick(2);
    check("stream first valid", 32'(id_valid), 32'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stream pc %0d", i), id_pc, 32'(4 * i));
      check($sformatf("stream inst %0d", i), id_inst, mem_word(32'(4 * i)));
      tick(1);
    end

    // Stall with head at 0x18: queue saturates, request stops, outputs hold
    check("stall log len", 32'(id_log.size()), 32'd6);
    id_ready = 1'b0;
    tick(6);
    check("stall req_valid", 32'(imem_req_valid), 32'd0);
    check("stall used", 32'(dut.used), 32'd4);
    check("stall hold pc", id_pc, 32'h18);
    check("stall hold inst", id_inst, mem_word(32'h18));
    id_ready = 1'b1;
    wait_log("drain", 14, 40);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain pc %0d", k), id_log[6 + k].pc, 32'(32'h18 + 4 * k));
    end
    check("drain no gap", 32'(id_log[9].cyc - id_log[6].cyc), 32'd3);

    // Round trip of request, wait, response with two outstanding: two words every three cycles
    do_reset(2);
    id_ready = 1'b1;
    wait_log("lat", 10, 60);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("lat pc %0d", i), id_log[i].pc, 32'(4 * i));
      check($sformatf("lat spacing %0d", i), 32'(id_log[i + 2].cyc - id_log[i].cyc), 32'd3);
    end
    check("lat max outstanding", 32'(max_out_seen <= 2), 32'd1);

    // Redirect to 0x40 with pc0/pc4 filled and pc8/pc12 in flight (pc8 arriving now)
    do_reset(2);
    tick(5);
    check("redir pre head", id_pc, 32'h0);
    check("redir pre used", 32'(dut.used), 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    check("redir req blocked", 32'(imem_req_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check("redir bubble valid", 32'(id_valid), 32'd0);
    check("redir bubble pc", id_pc, 32'h0);
    check("redir bubble inst", id_inst, 32'h0);
    check("redir drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    check("redir new addr", imem_req_addr, 32'h40);
    wait_log("redir", 3, 30);
    check("redir first pc", id_log[0].pc, 32'h40);
    check("redir first inst", id_log[0].inst, mem_word(32'h40));
    check("redir second pc", id_log[1].pc, 32'h44);
    check("redir third pc", id_log[2].pc, 32'h48);

    // Redirect to 0x80 alongside a response and a decode handshake, then 0x100 next cycle
    do_reset(1);
    id_ready = 1'b1;
    tick(4);
    check("b2b head", id_pc, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick(1);
    redirect_pc = 32'h100;
    check("b2b bubble", 32'(id_valid), 32'd0);
    tick(1);
    redirect_valid = 1'b0;
    check("b2b drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    check("b2b addr", imem_req_addr, 32'h100);
    wait_log("b2b", 5, 30);
    check("b2b squashed pc", id_log[2].pc, 32'h8);
    check("b2b first new pc", id_log[3].pc, 32'h100);
    check("b2b next pc", id_log[4].pc, 32'h104);

    // Reset while three entries are held
    do_reset(1);
    tick(3);
    check("rst pre used", 32'(dut.used), 32'd3);
    rst = 1'b1;
    tick(1);
    check("rst mid id_valid", 32'(id_valid), 32'd0);
    check("rst mid req_valid", 32'(imem_req_valid), 32'd0);
    check("rst mid id_pc", id_pc, 32'h0);
    rst      = 1'b0;
    id_ready = 1'b1;
    tick(2);
    check("rst restart valid", 32'(id_valid), 32'd1);
    check("rst restart pc", id_pc, 32'h0);
    check("rst restart inst", id_inst, mem_word(32'h0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
